// File: rtl/cronometro_pkg.sv
// Shared types and constants for the shot-clock control stage.
package cronometro_pkg;

    typedef enum logic [2:0] {
        CARREGA,
        PARADO,
        CORRENDO,
        PAUSADO,
        ESTOURO
    } estado_t;

    localparam logic [1:0] DEZ24    = 2'd2;
    localparam logic [3:0] UNID24   = 4'd4;
    localparam logic [1:0] DEZ14    = 2'd1;
    localparam logic [3:0] UNID14   = 4'd4;
    localparam int         LIMITE14 = 14;

    // Bit positions of the operator buttons in the edge-detector vector
    localparam int B_REIN24 = 0;
    localparam int B_REIN14 = 1;
    localparam int B_PAUSA  = 2;
    localparam int B_INICIA = 3;
    localparam int N_BOTOES = 4;

    // True when the BCD value dez:unid is strictly below LIMITE14
    function automatic logic abaixo_limite14(input logic [1:0] dez, input logic [3:0] unid);
        return (dez < 2'(LIMITE14 / 10)) ||
               ((dez == 2'(LIMITE14 / 10)) && (unid < 4'(LIMITE14 % 10)));
    endfunction

endpackage

// File: rtl/controle_cronometro_if.sv
// Link between the control stage and the shot-clock counter.
interface controle_cronometro_if;

    logic       pulso_seg;
    logic       botao;
    logic [1:0] dez_preset;
    logic [3:0] unid_preset;
    logic       casoEsp;
    logic       sinal;
    logic       sinal15;
    logic [1:0] dezena;
    logic [3:0] unidade;

    modport master (
        output pulso_seg, botao, dez_preset, unid_preset, casoEsp,
        input  sinal, sinal15, dezena, unidade
    );

    modport slave (
        input  pulso_seg, botao, dez_preset, unid_preset, casoEsp,
        output sinal, sinal15, dezena, unidade
    );

endinterface

// File: rtl/detector_borda.sv
// Rising-edge detector for N level inputs; previous levels reset high so a
// button held through reset does not produce an event.
module detector_borda #(
    parameter int N = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] nivel,
    output logic [N-1:0] borda
);

    logic [N-1:0] nivel_p1;

    always_ff @(posedge clock) begin
        if (reset) nivel_p1 <= '1;
        else       nivel_p1 <= nivel;
    end

    assign borda = nivel & ~nivel_p1;

endmodule

// File: rtl/controle_cronometro.sv
// Control stage for the shot-clock counter: per-second enable, load strobe,
// presets, hold flag, horn and 15-second warning.
module controle_cronometro
    import cronometro_pkg::*;
#(
    parameter int CLK_DIV     = 50000000,
    parameter int BUZZ_CYCLES = 100000000,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   bt_inicia,
    input  logic                   bt_pausa,
    input  logic                   bt_rein24,
    input  logic                   bt_rein14,
    controle_cronometro_if.master  cron,
    output logic                   buzina,
    output logic                   aviso15
);

    localparam int               PRE_W   = $clog2(CLK_DIV);
    localparam int               BUZ_W   = $clog2(BUZZ_CYCLES + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [BUZ_W-1:0] BUZ_MAX = BUZ_W'(BUZZ_CYCLES);
    localparam logic             AUTO    = (AUTO_RELOAD != 0);

    estado_t            estado;
    estado_t            estado_ret;
    logic [PRE_W-1:0]   prescaler;
    logic [BUZ_W-1:0]   cont_buz;
    logic               sinal15_p1;
    logic [N_BOTOES-1:0] nivel;
    logic [N_BOTOES-1:0] borda;

    logic ev_rein24, ev_rein14, ev_pausa, ev_inicia, recarga;

    assign nivel[B_REIN24] = bt_rein24;
    assign nivel[B_REIN14] = bt_rein14;
    assign nivel[B_PAUSA]  = bt_pausa;
    assign nivel[B_INICIA] = bt_inicia;

    detector_borda #(.N(N_BOTOES)) u_borda (
        .clock (clock),
        .reset (reset),
        .nivel (nivel),
        .borda (borda)
    );

    // Only the highest-priority edge of the cycle survives
    assign ev_rein24 = borda[B_REIN24];
    assign ev_rein14 = borda[B_REIN14] & ~borda[B_REIN24];
    assign ev_pausa  = borda[B_PAUSA]  & ~borda[B_REIN24] & ~borda[B_REIN14];
    assign ev_inicia = borda[B_INICIA] & ~borda[B_REIN24] & ~borda[B_REIN14] & ~borda[B_PAUSA];
    assign recarga   = ev_rein24 | (ev_rein14 & abaixo_limite14(cron.dezena, cron.unidade));

    always_ff @(posedge clock) begin
        if (reset) begin
            estado           <= CARREGA;
            estado_ret       <= PARADO;
            prescaler        <= '0;
            cont_buz         <= '0;
            sinal15_p1       <= 1'b1;
            cron.pulso_seg   <= 1'b0;
            cron.botao       <= 1'b0;
            cron.casoEsp     <= 1'b1;
            cron.dez_preset  <= DEZ24;
            cron.unid_preset <= UNID24;
            buzina           <= 1'b0;
            aviso15          <= 1'b0;
        end else begin
            cron.pulso_seg <= 1'b0;
            cron.botao     <= 1'b0;
            cron.casoEsp   <= 1'b1;
            aviso15        <= 1'b0;
            sinal15_p1     <= cron.sinal15;

            // Horn timer runs on its own once started; the FSM only starts or kills it
            if (buzina) begin
                if (cont_buz == BUZ_MAX) begin
                    buzina   <= 1'b0;
                    cont_buz <= '0;
                end else begin
                    cont_buz <= cont_buz + 1'b1;
                end
            end

            case (estado)
                CARREGA: begin
                    cron.botao   <= 1'b1;
                    prescaler    <= '0;
                    estado       <= estado_ret;
                    cron.casoEsp <= !(AUTO && (estado_ret == CORRENDO));
                end
                default: begin
                    if (recarga) begin
                        cron.dez_preset  <= ev_rein24 ? DEZ24  : DEZ14;
                        cron.unid_preset <= ev_rein24 ? UNID24 : UNID14;
                        estado_ret       <= (estado == CORRENDO) ? CORRENDO : PARADO;
                        estado           <= CARREGA;
                        buzina           <= 1'b0;
                        cont_buz         <= '0;
                    end else begin
                        case (estado)
                            PARADO: begin
                                if (ev_inicia && !cron.sinal) begin
                                    estado       <= CORRENDO;
                                    cron.casoEsp <= !AUTO;
                                end
                            end
                            CORRENDO: begin
                                if (cron.sinal15 && !sinal15_p1) aviso15 <= 1'b1;
                                if (cron.sinal && !AUTO) begin
                                    estado   <= ESTOURO;
                                    buzina   <= 1'b1;
                                    cont_buz <= BUZ_W'(1);
                                end else if (ev_pausa) begin
                                    estado <= PAUSADO;
                                end else begin
                                    cron.casoEsp <= !AUTO;
                                    if (prescaler == PRE_MAX) begin
                                        prescaler      <= '0;
                                        cron.pulso_seg <= 1'b1;
                                    end else begin
                                        prescaler <= prescaler + 1'b1;
                                    end
                                    // Self-reloading counter: horn starts but the run continues
                                    if (cron.sinal && !buzina) begin
                                        buzina   <= 1'b1;
                                        cont_buz <= BUZ_W'(1);
                                    end
                                end
                            end
                            PAUSADO: begin
                                if (ev_pausa || ev_inicia) begin
                                    estado       <= CORRENDO;
                                    cron.casoEsp <= !AUTO;
                                end
                            end
                            ESTOURO: begin
                                if (buzina && (cont_buz == BUZ_MAX)) estado <= PARADO;
                            end
                            default: estado <= PARADO;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_cronometro.sv
// Scoreboard bench for controle_cronometro with CLK_DIV=4, BUZZ_CYCLES=3.
module tb_controle_cronometro;

    localparam logic [3:0] M_REIN24 = 4'b0001;
    localparam logic [3:0] M_REIN14 = 4'b0010;
    localparam logic [3:0] M_PAUSA  = 4'b0100;
    localparam logic [3:0] M_INICIA = 4'b1000;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       buzina;
    logic       aviso15;

    controle_cronometro_if cron ();

    controle_cronometro #(
        .CLK_DIV     (4),
        .BUZZ_CYCLES (3),
        .AUTO_RELOAD (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bt_inicia (botoes[3]),
        .bt_pausa  (botoes[2]),
        .bt_rein24 (botoes[0]),
        .bt_rein14 (botoes[1]),
        .cron      (cron),
        .buzina    (buzina),
        .aviso15   (aviso15)
    );

    always #5 clock = ~clock;

    int ciclo = 0;
    always @(posedge clock) ciclo <= ciclo + 1;

    int n_comp = 0;
    int n_erro = 0;

    int         q_pulso[$];
    int         q_aviso[$];
    int         q_botao[$];
    logic [5:0] q_preset[$];

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_erro++;
            $display("FAIL %s: obtido %0d esperado %0d (ciclo %0d)", tag, obs, esp, ciclo);
        end
    endtask

    // Pop expected events as the DUT emits them; stale heads are misses
    always @(negedge clock) begin
        if (cron.pulso_seg === 1'b1) begin
            if (q_pulso.size() == 0) confere("pulso_inesperado", ciclo, -1);
            else                     confere("pulso_ciclo", ciclo, q_pulso.pop_front());
        end
        while (q_pulso.size() > 0 && q_pulso[0] < ciclo)
            confere("pulso_ausente", ciclo, q_pulso.pop_front());

        if (aviso15 === 1'b1) begin
            if (q_aviso.size() == 0) confere("aviso_inesperado", ciclo, -1);
            else                     confere("aviso_ciclo", ciclo, q_aviso.pop_front());
        end
        while (q_aviso.size() > 0 && q_aviso[0] < ciclo)
            confere("aviso_ausente", ciclo, q_aviso.pop_front());

        if (cron.botao === 1'b1) begin
            if (q_botao.size() == 0) begin
                confere("botao_inesperado", ciclo, -1);
            end else begin
                confere("botao_ciclo", ciclo, q_botao.pop_front());
                confere("botao_preset", {cron.dez_preset, cron.unid_preset}, q_preset.pop_front());
            end
        end
        while (q_botao.size() > 0 && q_botao[0] < ciclo) begin
            confere("botao_ausente", ciclo, q_botao.pop_front());
            void'(q_preset.pop_front());
        end
    end

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic ate(input int c);
        while (ciclo < c) passo();
    endtask

    task automatic aperta(input logic [3:0] m);
        botoes = m;
        passo();
        botoes = 4'b0000;
    endtask

    task automatic espera_botao(input logic [5:0] preset);
        q_botao.push_back(ciclo + 1);
        q_preset.push_back(preset);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: tempo esgotado no ciclo %0d", ciclo);
        $fatal(1);
    end

    initial begin
        int e, p, r, s, l;
        reset        = 1'b1;
        botoes       = 4'b0000;
        cron.sinal   = 1'b0;
        cron.sinal15 = 1'b0;
        cron.dezena  = 2'd2;
        cron.unidade = 4'd4;
        repeat (3) passo();

        confere("rst_botao",   cron.botao, 0);
        confere("rst_pulso",   cron.pulso_seg, 0);
        confere("rst_buzina",  buzina, 0);
        confere("rst_aviso",   aviso15, 0);
        confere("rst_casoEsp", cron.casoEsp, 1);
        confere("rst_dez",     cron.dez_preset, 2);
        confere("rst_unid",    cron.unid_preset, 4);

        // Load after reset, then idle in PARADO with no count enable
        reset = 1'b0;
        espera_botao(6'h24);
        repeat (6) passo();

        // Run, pause after two counts, resume keeps prescaler phase
        aperta(M_INICIA);
        e = ciclo;
        q_pulso.push_back(e + 4);
        q_pulso.push_back(e + 8);
        confere("casoEsp_correndo", cron.casoEsp, 1);
        ate(e + 10);
        aperta(M_PAUSA);
        p = ciclo;
        ate(p + 6);
        aperta(M_PAUSA);
        r = ciclo;
        q_pulso.push_back(r + 2);
        q_pulso.push_back(r + 6);

        // 15-second warning while running
        ate(r + 3);
        cron.sinal15 = 1'b1;
        q_aviso.push_back(r + 4);
        ate(r + 7);
        cron.sinal15 = 1'b0;

        // Zero reached: horn for exactly three cycles, inicia ignored meanwhile
        ate(r + 8);
        confere("buzina_antes", buzina, 0);
        cron.sinal = 1'b1;
        passo();
        s = ciclo;
        confere("buzina_c0", buzina, 1);
        aperta(M_INICIA);
        confere("buzina_c1", buzina, 1);
        passo();
        confere("buzina_c2", buzina, 1);
        passo();
        confere("buzina_fim", buzina, 0);
        confere("buzina_duracao", ciclo - s, 3);

        // PARADO at zero: inicia ignored
        aperta(M_INICIA);
        repeat (6) passo();
        cron.sinal = 1'b0;
        repeat (6) passo();

        // rein14 at 19 is ignored, at 12 it loads 14
        cron.dezena  = 2'd1;
        cron.unidade = 4'd9;
        aperta(M_REIN14);
        repeat (3) passo();
        confere("rein14_ign_dez",  cron.dez_preset, 2);
        confere("rein14_ign_unid", cron.unid_preset, 4);
        cron.unidade = 4'd2;
        aperta(M_REIN14);
        espera_botao(6'h14);
        passo();
        confere("rein14_dez",  cron.dez_preset, 1);
        confere("rein14_unid", cron.unid_preset, 4);
        repeat (4) passo();

        // rein24 and pausa together while running: reload wins, run resumes from phase 0
        aperta(M_INICIA);
        e = ciclo;
        q_pulso.push_back(e + 4);
        ate(e + 5);
        aperta(M_REIN24 | M_PAUSA);
        l = ciclo;
        espera_botao(6'h24);
        q_pulso.push_back(l + 5);
        q_pulso.push_back(l + 9);

        // Reset during the horn
        ate(l + 10);
        cron.sinal = 1'b1;
        passo();
        confere("buzina_estouro2", buzina, 1);
        reset = 1'b1;
        passo();
        confere("buzina_reset", buzina, 0);
        confere("botao_reset",  cron.botao, 0);
        cron.sinal = 1'b0;
        passo();
        reset = 1'b0;
        espera_botao(6'h24);
        repeat (5) passo();

        confere("fila_pulso", q_pulso.size(), 0);
        confere("fila_aviso", q_aviso.size(), 0);
        confere("fila_botao", q_botao.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
        $finish;
    end

endmodule
